// File: rtl/parity_serial_tx.sv
// Serial frame transmitter: start bit, LSB-first data, odd (XNOR) parity, stop bit.
// Define PARITY_SERIAL_TX_TWO_STOP_EN to send two stop bits instead of one.
module parity_serial_tx #(
    parameter int DATA_WIDTH = 8,
    parameter int BIT_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  data_valid,
    output logic                  ready,
    output logic                  serial_out,
    output logic                  busy,
    output logic                  done
);

    localparam int CYC_W = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
    localparam int BIT_W = $clog2(DATA_WIDTH + 1);
`ifdef PARITY_SERIAL_TX_TWO_STOP_EN
    localparam int STOP_BITS = 2;
`else
    localparam int STOP_BITS = 1;
`endif
    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(BIT_CYCLES - 1);
    localparam logic [BIT_W-1:0] DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0] STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    // XNOR reduction: total ones across word plus parity bit is odd.
    function automatic logic odd_parity(input logic [DATA_WIDTH-1:0] word);
        return ~^word;
    endfunction

    state_t                state_r, state_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_s;
    logic                  parity_r, parity_s;
    logic [BIT_W-1:0]      bit_r, bit_s;
    logic [CYC_W-1:0]      cyc_r, cyc_s;
    logic                  serial_r, serial_s;
    logic                  ready_r, ready_s;
    logic                  busy_r, busy_s;
    logic                  done_r, done_s;
    logic                  last_cyc_s;

    assign last_cyc_s = (cyc_r == CYC_LAST);

    // Next-state and next-output decode; outputs are registered from these values.
    always_comb begin
        state_s  = state_r;
        shift_s  = shift_r;
        parity_s = parity_r;
        bit_s    = bit_r;
        cyc_s    = cyc_r;
        serial_s = serial_r;
        ready_s  = 1'b0;
        busy_s   = 1'b1;
        done_s   = 1'b0;

        case (state_r)
            ST_IDLE: begin
                cyc_s = {CYC_W{1'b0}};
                if (data_valid && ready_r) begin
                    shift_s  = data_in;
                    parity_s = odd_parity(data_in);
                    state_s  = ST_START;
                    serial_s = 1'b0;
                end else begin
                    serial_s = 1'b1;
                    ready_s  = 1'b1;
                    busy_s   = 1'b0;
                end
            end

            ST_START: begin
                if (last_cyc_s) begin
                    state_s  = ST_DATA;
                    cyc_s    = {CYC_W{1'b0}};
                    bit_s    = {BIT_W{1'b0}};
                    serial_s = shift_r[0];
                end else begin
                    cyc_s    = cyc_r + CYC_W'(1);
                    serial_s = 1'b0;
                end
            end

            ST_DATA: begin
                if (last_cyc_s) begin
                    cyc_s   = {CYC_W{1'b0}};
                    shift_s = shift_r >> 1;
                    if (bit_r == DATA_LAST) begin
                        state_s  = ST_PARITY;
                        bit_s    = {BIT_W{1'b0}};
                        serial_s = parity_r;
                    end else begin
                        bit_s    = bit_r + BIT_W'(1);
                        serial_s = shift_s[0];
                    end
                end else begin
                    cyc_s    = cyc_r + CYC_W'(1);
                    serial_s = shift_r[0];
                end
            end

            ST_PARITY: begin
                if (last_cyc_s) begin
                    state_s  = ST_STOP;
                    cyc_s    = {CYC_W{1'b0}};
                    bit_s    = {BIT_W{1'b0}};
                    serial_s = 1'b1;
                end else begin
                    cyc_s    = cyc_r + CYC_W'(1);
                    serial_s = parity_r;
                end
            end

            ST_STOP: begin
                serial_s = 1'b1;
                if (last_cyc_s) begin
                    cyc_s = {CYC_W{1'b0}};
                    // The bit counter is reused to count stop bits.
                    if (bit_r == STOP_LAST) begin
                        state_s = ST_IDLE;
                        bit_s   = {BIT_W{1'b0}};
                        ready_s = 1'b1;
                        busy_s  = 1'b0;
                        done_s  = 1'b1;
                    end else begin
                        bit_s = bit_r + BIT_W'(1);
                    end
                end else begin
                    cyc_s = cyc_r + CYC_W'(1);
                end
            end

            default: begin
                state_s  = ST_IDLE;
                shift_s  = {DATA_WIDTH{1'b0}};
                parity_s = 1'b0;
                bit_s    = {BIT_W{1'b0}};
                cyc_s    = {CYC_W{1'b0}};
                serial_s = 1'b1;
                ready_s  = 1'b1;
                busy_s   = 1'b0;
            end
        endcase
    end

    // State, datapath and output registers with synchronous reset priority.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r  <= ST_IDLE;
            shift_r  <= {DATA_WIDTH{1'b0}};
            parity_r <= 1'b0;
            bit_r    <= {BIT_W{1'b0}};
            cyc_r    <= {CYC_W{1'b0}};
            serial_r <= 1'b1;
            ready_r  <= 1'b1;
            busy_r   <= 1'b0;
            done_r   <= 1'b0;
        end else begin
            state_r  <= state_s;
            shift_r  <= shift_s;
            parity_r <= parity_s;
            bit_r    <= bit_s;
            cyc_r    <= cyc_s;
            serial_r <= serial_s;
            ready_r  <= ready_s;
            busy_r   <= busy_s;
            done_r   <= done_s;
        end
    end

    assign serial_out = serial_r;
    assign ready      = ready_r;
    assign busy       = busy_r;
    assign done       = done_r;

endmodule

// File: tb/tb_parity_serial_tx.sv
// Directed bench for parity_serial_tx (DATA_WIDTH=8, BIT_CYCLES=4).
// Expected frame length follows PARITY_SERIAL_TX_TWO_STOP_EN when defined.
module tb_parity_serial_tx;

    localparam int DW = 8;
    localparam int BC = 4;
`ifdef PARITY_SERIAL_TX_TWO_STOP_EN
    localparam int FRAME_BITS = DW + 4;
`else
    localparam int FRAME_BITS = DW + 3;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [DW-1:0] data_in = 8'h00;
    logic          data_valid = 1'b0;
    logic          ready, serial_out, busy, done;

    int total = 0;
    int bad   = 0;

    parity_serial_tx #(.DATA_WIDTH(DW), .BIT_CYCLES(BC)) dut (
        .clk       (clk),
        .reset     (reset),
        .data_in   (data_in),
        .data_valid(data_valid),
        .ready     (ready),
        .serial_out(serial_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_idle(input string tag, input logic exp_done);
        chk({tag, "_serial"}, {31'd0, serial_out}, 32'd1);
        chk({tag, "_ready"},  {31'd0, ready},      32'd1);
        chk({tag, "_busy"},   {31'd0, busy},       32'd0);
        chk({tag, "_done"},   {31'd0, done},       {31'd0, exp_done});
    endtask

    // Called just after the acceptance edge; walks the whole frame, ends in the done cycle.
    task automatic run_frame(input string tag, input logic [DW-1:0] word, input logic par,
                             input logic [DW-1:0] later_data, input logic keep_valid);
        logic exp_bit;
        int   idx;
        for (int c = 0; c < FRAME_BITS * BC; c++) begin
            if (c == 0) data_valid = keep_valid;
            if (c == 10) data_in = later_data;
            idx = c / BC;
            if (idx == 0)            exp_bit = 1'b0;
            else if (idx <= DW)      exp_bit = word[idx-1];
            else if (idx == DW + 1)  exp_bit = par;
            else                     exp_bit = 1'b1;
            chk({tag, "_bit"},   {31'd0, serial_out}, {31'd0, exp_bit});
            chk({tag, "_busy"},  {31'd0, busy},       32'd1);
            chk({tag, "_ready"}, {31'd0, ready},      32'd0);
            chk({tag, "_done"},  {31'd0, done},       32'd0);
            step();
        end
        chk_idle({tag, "_end"}, 1'b1);
    endtask

    task automatic send(input string tag, input logic [DW-1:0] word, input logic par);
        data_in    = word;
        data_valid = 1'b1;
        step();
        run_frame(tag, word, par, word, 1'b0);
        step();
        chk_idle({tag, "_after"}, 1'b0);
    endtask

    initial begin
        // 1: reset then idle
        step();
        step();
        chk_idle("rst", 1'b0);
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            step();
            chk_idle("idle", 1'b0);
        end

        // 2: basic frame 0xA5 (four ones -> parity 1)
        send("a5", 8'hA5, 1'b1);

        // 3: parity values
        send("p00", 8'h00, 1'b1);
        send("p01", 8'h01, 1'b0);
        send("p07", 8'h07, 1'b0);
        send("pff", 8'hFF, 1'b1);

        // 4: back-to-back with data_valid held, data_in changed mid-frame
        data_in    = 8'h3C;
        data_valid = 1'b1;
        step();
        run_frame("b2b1", 8'h3C, 1'b1, 8'hC3, 1'b1);
        step();
        run_frame("b2b2", 8'hC3, 1'b1, 8'h00, 1'b0);
        step();
        chk_idle("b2b_after", 1'b0);

        // 5: reset during the third data bit of 0xFF
        data_in    = 8'hFF;
        data_valid = 1'b1;
        step();
        data_valid = 1'b0;
        for (int c = 0; c < 13; c++) begin
            chk("mid_busy", {31'd0, busy}, 32'd1);
            step();
        end
        chk("mid_bit3", {31'd0, serial_out}, 32'd1);
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk_idle("mid_rst", 1'b0);
        for (int i = 0; i < 50; i++) begin
            step();
            chk("mid_nodone", {31'd0, done}, 32'd0);
        end
        send("post81", 8'h81, 1'b1);

        // 6: 0x5A, stop length depends on the two-stop build option
        send("s5a", 8'h5A, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
